// File: rtl/snac_db15_scanner.sv
// SNAC DB15 adapter scanner: drives load/clock to the adapter, deserialises two
// 12-button pads, debounces across consecutive scans and presents MiSTer-layout words.
module snac_db15_scanner #(
   parameter int unsigned CLK_DIV   = 48,
   parameter int unsigned FRAME_GAP = 950
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        scan_done
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam int unsigned NBITS = 24;
   localparam int unsigned BIT_W = 5;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

   typedef enum logic [2:0] {
      ST_DISABLED,
      ST_LOAD,
      ST_SETTLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_COMMIT,
      ST_GAP
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               clk_next;
   logic               load_next;
   logic               done_next;

   logic [1:0]         data_sync;
   logic               pressed;
   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic [GAP_W-1:0]   gap_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [NBITS-1:0]   raw;
   logic [NBITS-1:0]   prev;

   // Serial order Up,Down,Left,Right,B1..B6,Start,Select -> MiSTer joystick layout
   function automatic logic [15:0] map_player(input logic [11:0] p);
      return {4'b0000, p[11], p[10], p[9:4], p[0], p[1], p[2], p[3]};
   endfunction

   // Adapter data is asynchronous; wire low means pressed
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         data_sync <= 2'b11;
      end else begin
         data_sync <= {data_sync[0], joy_data};
      end
   end

   assign pressed = ~data_sync[1];

   // Tick divider; parked at 0 while disabled and during COMMIT so GAP gets whole ticks
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (!enable || state == ST_COMMIT || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_DISABLED;
         joy_clk   <= 1'b1;
         joy_load  <= 1'b1;
         scan_done <= 1'b0;
      end else begin
         state     <= state_next;
         joy_clk   <= clk_next;
         joy_load  <= load_next;
         scan_done <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_DISABLED: if (tick) state_next = ST_LOAD;
         ST_LOAD:     if (tick) state_next = ST_SETTLE;
         ST_SETTLE:   if (tick) state_next = ST_SHIFT_LO;
         ST_SHIFT_LO: if (tick) state_next = ST_SHIFT_HI;
         ST_SHIFT_HI: begin
            if (tick) begin
               state_next = (bit_cnt == BIT_LAST) ? ST_COMMIT : ST_SHIFT_LO;
            end
         end
         ST_COMMIT:   state_next = ST_GAP;
         ST_GAP:      if (tick && gap_cnt == GAP_LAST) state_next = ST_LOAD;
         default:     state_next = ST_DISABLED;
      endcase
      // Dropping enable aborts from anywhere, without a scan_done pulse
      if (!enable) begin
         state_next = ST_DISABLED;
      end
      clk_next  = (state_next != ST_SHIFT_LO);
      load_next = (state_next != ST_LOAD);
      done_next = (state_next == ST_COMMIT);
   end

   // Shift capture, debounce against the previous scan and output update
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         raw       <= '0;
         prev      <= '0;
         joystick1 <= '0;
         joystick2 <= '0;
      end else if (!enable) begin
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         raw       <= '0;
         prev      <= '0;
         joystick1 <= '0;
         joystick2 <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               bit_cnt <= '0;
            end
            ST_SHIFT_LO: begin
               if (tick) begin
                  raw[bit_cnt] <= pressed;
               end
            end
            ST_SHIFT_HI: begin
               if (tick && bit_cnt != BIT_LAST) begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            ST_COMMIT: begin
               bit_cnt <= '0;
               gap_cnt <= '0;
               prev    <= raw;
               if (raw == '1) begin
                  joystick1 <= '0;
                  joystick2 <= '0;
               end else if (raw == prev) begin
                  joystick1 <= map_player(raw[11:0]);
                  joystick2 <= map_player(raw[23:12]);
               end
            end
            ST_GAP: begin
               if (tick) begin
                  gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
